// File: rtl/lab9_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lab9_seq_ctrl : word-in / result-out sequencer for a 3-bit serial       |
// | non-overlapping pattern detector.                     rev 1.0           |
// +--------------------------------------------------------------------------+
module lab9_seq_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [2:0]       in_pattern,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_count,
   output logic [CNT_W-1:0] out_last_pos,
   output logic             match_pulse,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic               ready_en;
   logic [WIDTH-1:0]   shreg;
   logic [2:0]         pat;
   logic [1:0]         win;
   logic [1:0]         fill;
   logic [CNT_W-1:0]   idx;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   last_pos;
   logic               pulse;
   logic               cur_bit;
   logic               accept;
   logic               hit;

   assign cur_bit = shreg[WIDTH-1];
   assign accept  = in_valid && in_ready;
   assign hit     = (state == SHIFT) && (fill == 2'd2) && ({win, cur_bit} == pat);

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state)
         IDLE: begin
            // ready_en keeps in_ready low for the cycle right after reset release
            in_ready = ready_en;
            if (accept)
               state_nxt = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (idx == '0)
               state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state    <= IDLE;
         ready_en <= 1'b0;
         shreg    <= '0;
         pat      <= '0;
         win      <= '0;
         fill     <= '0;
         idx      <= '0;
         count    <= '0;
         last_pos <= '0;
         pulse    <= 1'b0;
      end else begin
         state    <= state_nxt;
         ready_en <= 1'b1;
         pulse    <= hit;
         if (accept) begin
            shreg    <= in_data;
            pat      <= in_pattern;
            win      <= '0;
            fill     <= '0;
            idx      <= CNT_W'(WIDTH - 1);
            count    <= '0;
            last_pos <= '0;
         end else if (state == SHIFT) begin
            shreg <= shreg << 1;
            idx   <= idx - CNT_W'(1);
            if (hit) begin
               // a match consumes its three bits; the next one starts from scratch
               count    <= count + CNT_W'(1);
               last_pos <= idx;
               win      <= '0;
               fill     <= '0;
            end else begin
               win  <= {win[0], cur_bit};
               fill <= (fill == 2'd2) ? 2'd2 : fill + 2'd1;
            end
         end
      end
   end

   assign out_count    = count;
   assign out_last_pos = last_pos;
   assign match_pulse  = pulse;

endmodule
`default_nettype wire

// File: tb/tb_lab9_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lab9_seq_ctrl : directed + random bench with a queue-based model.     |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_lab9_seq_ctrl;

   localparam int WIDTH = 8;
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic             clock = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic [2:0]       in_pattern = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [CNT_W-1:0] out_count;
   logic [CNT_W-1:0] out_last_pos;
   logic             match_pulse;
   logic             busy;

   int checks = 0;
   int errors = 0;

   lab9_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clock        (clock),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_pattern   (in_pattern),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_count    (out_count),
      .out_last_pos (out_last_pos),
      .match_pulse  (match_pulse),
      .busy         (busy)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bits enter a history queue; three queued bits equal to the pattern form a
   // match and are discarded. mask[k] marks a pulse k cycles after acceptance.
   task automatic model(input logic [WIDTH-1:0] d, input logic [2:0] p,
                        output int cnt, output int last, output logic [WIDTH+1:0] mask);
      int hist[$];
      cnt  = 0;
      last = 0;
      mask = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         hist.push_back(int'(d[i]));
         if (hist.size() == 3) begin
            if (hist[0] * 4 + hist[1] * 2 + hist[2] == int'(p)) begin
               cnt++;
               last = i;
               mask[WIDTH - i + 1] = 1'b1;
               hist.delete();
            end else begin
               void'(hist.pop_front());
            end
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"},  in_ready,     0);
      check({tag, "_out_valid"}, out_valid,    0);
      check({tag, "_count"},     out_count,    0);
      check({tag, "_last_pos"},  out_last_pos, 0);
      check({tag, "_pulse"},     match_pulse,  0);
      check({tag, "_busy"},      busy,         0);
   endtask

   task automatic run_word(input logic [WIDTH-1:0] d, input logic [2:0] p, input int hold,
                           input bit keep_valid, input bit expect_ready_now);
      int cnt, last, w;
      logic [WIDTH+1:0] mask;
      model(d, p, cnt, last, mask);
      in_data    = d;
      in_pattern = p;
      in_valid   = 1'b1;
      out_ready  = 1'b0;
      w = 0;
      while (!in_ready && w < 50) begin
         tick();
         w++;
      end
      if (w >= 50) begin
         check("accept_timeout", w, 0);
         in_valid = 1'b0;
         return;
      end
      if (expect_ready_now)
         check("ready_immediate", w, 0);
      tick();
      in_valid = keep_valid;
      for (int k = 1; k <= WIDTH + 1; k++) begin
         check("pulse", match_pulse, mask[k]);
         check("out_valid_timing", out_valid, (k == WIDTH + 1) ? 1 : 0);
         check("busy", busy, 1);
         check("in_ready_low", in_ready, 0);
         in_data    = WIDTH'($urandom);
         in_pattern = 3'($urandom);
         if (k <= WIDTH)
            tick();
      end
      check("count", out_count, cnt);
      check("last_pos", out_last_pos, last);
      for (int h = 0; h < hold; h++) begin
         tick();
         check("hold_valid", out_valid, 1);
         check("hold_count", out_count, cnt);
         check("hold_last", out_last_pos, last);
         check("hold_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("post_valid", out_valid, 0);
      check("post_ready", in_ready, 1);
      check("post_busy", busy, 0);
      check("post_count", out_count, cnt);
   endtask

   initial begin
      // reset with in_valid asserted
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hA5;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_all_zero("reset");
      end
      rst = 1'b0;
      tick();
      check("release_ready", in_ready, 1);
      check("release_busy", busy, 0);
      in_valid = 1'b0;

      // directed scans
      run_word(8'b1010_0101, 3'b101, 0, 1'b0, 1'b1);
      run_word(8'b1010_1000, 3'b101, 0, 1'b0, 1'b1);
      run_word(8'hFF,        3'b111, 0, 1'b0, 1'b1);

      // backpressure, then the held word is taken right after the handshake
      run_word(8'h5A, 3'b010, 5, 1'b1, 1'b1);
      run_word(8'h3C, 3'b011, 0, 1'b0, 1'b1);

      // reset during the 4th SHIFT cycle
      in_data    = 8'hB6;
      in_pattern = 3'b110;
      in_valid   = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++)
         tick();
      check("midscan_busy", busy, 1);
      rst = 1'b1;
      tick();
      check_all_zero("midscan_reset");
      rst = 1'b0;
      tick();
      check("midscan_no_valid", out_valid, 0);
      check("midscan_ready", in_ready, 1);
      run_word(8'h00, 3'b000, 0, 1'b0, 1'b1);

      // random words
      for (int n = 0; n < 24; n++)
         run_word(WIDTH'($urandom), 3'($urandom), int'($urandom_range(0, 3)), 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
